stopwatch_ctrl: RTL and testbench
=================================

STOPWATCH_CTRL -- requirements
Module: stopwatch_ctrl

Interface
REQ-001 SHALL have parameter DEB_CYCLES, default 50000, meaning consecutive stable samples required to accept a button level change (1 ms at 50 MHz).
REQ-002 SHALL have parameter TICK_DIV, default 500000, meaning clock cycles per count tick (10 ms at 50 MHz).
REQ-003 SHALL have port clk  input  1  the single system clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port start_btn  input  1  raw start pushbutton, asynchronous to clk, active-low (0 = pressed).
REQ-006 SHALL have port stop_btn  input  1  raw stop pushbutton, asynchronous to clk, active-low (0 = pressed).
REQ-007 SHALL have port cnt_clr  output  1  one-cycle pulse commanding the downstream counter to clear to zero.
REQ-008 SHALL have port cnt_tick  output  1  one-cycle pulse commanding the downstream counter to increment by one.
REQ-009 SHALL have port running  output  1  high while in RUN.
REQ-010 SHALL have port state  output  2  current FSM state: IDLE=0, CLEAR=1, RUN=2, HOLD=3.

Function
REQ-011 SHALL pass each button through a two-flop synchronizer before any other use.
REQ-012 SHALL keep a debounced level per button, updated on the edge at which the synchronized input has differed from it for DEB_CYCLES consecutive samples; any matching sample restarts that button's debounce count at 0.
REQ-013 SHALL generate a press event for one cycle on the edge after a debounced level goes 1->0; release (0->1) generates no event.
REQ-014 SHALL, for a clean raw step sampled low at edge E, assert cnt_clr in the cycle following edge E+DEB_CYCLES+3.
REQ-015 SHALL implement transitions: IDLE: start->CLEAR, stop->IDLE; CLEAR: unconditionally->RUN after one cycle; RUN: start->CLEAR, stop->HOLD; HOLD: start->CLEAR, stop->HOLD.
REQ-016 SHALL give stop priority when start and stop events occur in the same cycle: RUN->HOLD, IDLE->IDLE, HOLD->HOLD.
REQ-017 SHALL ignore press events arriving while in CLEAR.
REQ-018 SHALL drive cnt_clr high exactly during CLEAR, i.e. one cycle per entry.
REQ-019 SHALL reset the tick prescaler to 0 in CLEAR, increment it each RUN cycle, wrap it from TICK_DIV-1 to 0, and hold its value in IDLE and HOLD.
REQ-020 SHALL pulse cnt_tick for the one RUN cycle in which the prescaler equals TICK_DIV-1, so the first tick arrives TICK_DIV cycles after leaving CLEAR.
REQ-021 SHALL never assert cnt_tick outside RUN, and never in the same cycle as cnt_clr.
REQ-022 SHALL resume a partially counted prescaler interval on HOLD->... only via CLEAR; i.e. HOLD exits only through start, which clears.
REQ-023 SHALL size the debounce and prescaler counters to hold DEB_CYCLES and TICK_DIV-1 exactly, without overflow.
REQ-024 SHALL hold a button pressed continuously and generate only one event.

Reset
REQ-025 SHALL, on rst low, asynchronously force state=IDLE, running=0, cnt_clr=0, cnt_tick=0, prescaler=0, debounce counts=0, synchronizer flops and debounced levels=1.
REQ-026 SHALL, when rst is asserted mid-RUN or mid-debounce, discard all pending events; no cnt_clr follows reset release without a new press.
REQ-027 SHALL, when rst is released, resume operation on the first rising clk edge.

Verification (DEB_CYCLES=4, TICK_DIV=5)
REQ-028 SHALL cover: reset, press start cleanly held 20 cycles -> one cnt_clr pulse at edge E+7, state 1->2, running=1, cnt_tick every 5 cycles thereafter.
REQ-029 SHALL cover: start_btn glitching low for 3 cycles only -> no debounced change, no cnt_clr, state stays IDLE.
REQ-030 SHALL cover: RUN then stop press -> state=HOLD, running=0, no cnt_tick for 200 cycles, prescaler value unchanged.
REQ-031 SHALL cover: start press while in RUN -> exactly one cnt_clr, prescaler restarts, first cnt_tick 5 cycles after CLEAR.
REQ-032 SHALL cover: start and stop raw steps at the same edge from RUN -> HOLD, no cnt_clr; from IDLE -> stays IDLE.
REQ-033 SHALL cover: rst pulsed low mid-RUN with start held -> all outputs 0 immediately, state IDLE, no event after release until start is released and pressed again.

Source files
------------

// File: rtl/stopwatch_ctrl.sv
// Stopwatch controller: two debounced pushbuttons (start/stop) drive a
// four-state FSM that issues clear/tick commands to a downstream counter.
// Buttons are raw, active-low and asynchronous to clk. Each one is
// synchronized, debounced and turned into a single-cycle press event.
// After reset a button must first be seen released before its presses
// count, so a button held through reset does not start the stopwatch.

module stopwatch_btn #(
   parameter int DEB_CYCLES = 50000
) (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_btn_raw,
   output logic o_press
);

   // Counter is wide enough to represent DEB_CYCLES itself.
   localparam int              DW       = $clog2(DEB_CYCLES + 1);
   localparam logic [DW-1:0]   DEB_LAST = DW'(DEB_CYCLES - 1);
   localparam logic [DW-1:0]   CNT_ONE  = DW'(1);
   localparam logic [DW-1:0]   CNT_ZERO = DW'(0);

   logic          r_sync1;
   logic          r_sync2;
   logic [1:0]    r_vld;
   logic          r_level;
   logic          r_level_d;
   logic [DW-1:0] r_deb_cnt;
   logic [DW-1:0] r_arm_cnt;
   logic          r_armed;
   logic          r_press;

   logic          w_level_nxt;
   logic [DW-1:0] w_deb_cnt_nxt;
   logic          w_armed_nxt;
   logic [DW-1:0] w_arm_cnt_nxt;
   logic          w_press_nxt;

   // Two-flop synchronizer; r_vld marks when r_sync2 carries a real sample.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_sync1 <= 1'b1;
         r_sync2 <= 1'b1;
         r_vld   <= 2'b00;
      end else begin
         r_sync1 <= i_btn_raw;
         r_sync2 <= r_sync1;
         r_vld   <= {r_vld[0], 1'b1};
      end
   end

   // Debounce: accept the new level on the DEB_CYCLES-th consecutive
   // differing sample; any matching sample restarts the count.
   always_comb begin
      w_level_nxt   = r_level;
      w_deb_cnt_nxt = r_deb_cnt;
      if (r_sync2 != r_level) begin
         if (r_deb_cnt == DEB_LAST) begin
            w_level_nxt   = r_sync2;
            w_deb_cnt_nxt = CNT_ZERO;
         end else begin
            w_deb_cnt_nxt = r_deb_cnt + CNT_ONE;
         end
      end else begin
         w_deb_cnt_nxt = CNT_ZERO;
      end
   end

   // Arming: the button must be seen released and stable for DEB_CYCLES
   // genuine samples after reset before its presses generate events.
   always_comb begin
      w_armed_nxt   = r_armed;
      w_arm_cnt_nxt = r_arm_cnt;
      if (r_armed) begin
         w_arm_cnt_nxt = CNT_ZERO;
      end else if (r_vld[1] && r_sync2 && r_level) begin
         if (r_arm_cnt == DEB_LAST) begin
            w_armed_nxt   = 1'b1;
            w_arm_cnt_nxt = CNT_ZERO;
         end else begin
            w_arm_cnt_nxt = r_arm_cnt + CNT_ONE;
         end
      end else begin
         w_arm_cnt_nxt = CNT_ZERO;
      end
   end

   // A press is a 1->0 change of the debounced level; release is silent.
   assign w_press_nxt = r_level_d & ~r_level & r_armed;

   // Debounce, arming and press-event state registers.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_level   <= 1'b1;
         r_level_d <= 1'b1;
         r_deb_cnt <= CNT_ZERO;
         r_arm_cnt <= CNT_ZERO;
         r_armed   <= 1'b0;
         r_press   <= 1'b0;
      end else begin
         r_level   <= w_level_nxt;
         r_level_d <= r_level;
         r_deb_cnt <= w_deb_cnt_nxt;
         r_arm_cnt <= w_arm_cnt_nxt;
         r_armed   <= w_armed_nxt;
         r_press   <= w_press_nxt;
      end
   end

   assign o_press = r_press;

endmodule

module stopwatch_ctrl #(
   parameter int DEB_CYCLES = 50000,
   parameter int TICK_DIV   = 500000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start_btn,
   input  logic       stop_btn,
   output logic       cnt_clr,
   output logic       cnt_tick,
   output logic       running,
   output logic [1:0] state
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_CLEAR = 2'd1,
      S_RUN   = 2'd2,
      S_HOLD  = 2'd3
   } state_t;

   // Prescaler is wide enough to hold TICK_DIV-1.
   localparam int            PW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);
   localparam logic [PW-1:0] PRE_ONE  = PW'(1);
   localparam logic [PW-1:0] PRE_ZERO = PW'(0);

   state_t        r_state;
   logic [PW-1:0] r_presc;
   logic          r_cnt_clr;
   logic          r_cnt_tick;
   logic          r_running;

   state_t        w_state_nxt;
   logic [PW-1:0] w_presc_nxt;
   logic          w_start_evt;
   logic          w_stop_evt;

   stopwatch_btn #(
      .DEB_CYCLES (DEB_CYCLES)
   ) u_start_btn (
      .i_clk     (clk),
      .i_rst_n   (rst),
      .i_btn_raw (start_btn),
      .o_press   (w_start_evt)
   );

   stopwatch_btn #(
      .DEB_CYCLES (DEB_CYCLES)
   ) u_stop_btn (
      .i_clk     (clk),
      .i_rst_n   (rst),
      .i_btn_raw (stop_btn),
      .o_press   (w_stop_evt)
   );

   // Next-state logic; stop wins when both events land in the same cycle,
   // and events arriving during CLEAR are dropped.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE: begin
            if (w_stop_evt) begin
               w_state_nxt = S_IDLE;
            end else if (w_start_evt) begin
               w_state_nxt = S_CLEAR;
            end else begin
               w_state_nxt = S_IDLE;
            end
         end
         S_CLEAR: begin
            w_state_nxt = S_RUN;
         end
         S_RUN: begin
            if (w_stop_evt) begin
               w_state_nxt = S_HOLD;
            end else if (w_start_evt) begin
               w_state_nxt = S_CLEAR;
            end else begin
               w_state_nxt = S_RUN;
            end
         end
         S_HOLD: begin
            if (w_stop_evt) begin
               w_state_nxt = S_HOLD;
            end else if (w_start_evt) begin
               w_state_nxt = S_CLEAR;
            end else begin
               w_state_nxt = S_HOLD;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // Prescaler: zeroed in CLEAR, counts and wraps in RUN, frozen otherwise.
   always_comb begin
      w_presc_nxt = r_presc;
      case (r_state)
         S_CLEAR: begin
            w_presc_nxt = PRE_ZERO;
         end
         S_RUN: begin
            if (r_presc == PRE_LAST) begin
               w_presc_nxt = PRE_ZERO;
            end else begin
               w_presc_nxt = r_presc + PRE_ONE;
            end
         end
         default: begin
            w_presc_nxt = r_presc;
         end
      endcase
   end

   // State, prescaler and registered outputs; outputs are computed from the
   // next state so they line up with the state they describe.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state    <= S_IDLE;
         r_presc    <= PRE_ZERO;
         r_cnt_clr  <= 1'b0;
         r_cnt_tick <= 1'b0;
         r_running  <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_presc    <= w_presc_nxt;
         r_cnt_clr  <= (w_state_nxt == S_CLEAR);
         r_cnt_tick <= (w_state_nxt == S_RUN) && (w_presc_nxt == PRE_LAST);
         r_running  <= (w_state_nxt == S_RUN);
      end
   end

   assign cnt_clr  = r_cnt_clr;
   assign cnt_tick = r_cnt_tick;
   assign running  = r_running;
   assign state    = r_state;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed scoreboard bench for stopwatch_ctrl with DEB_CYCLES=4, TICK_DIV=5.
// Inputs change on the falling edge; a raw step driven there is first
// sampled at the next rising edge E. Expected cnt_clr / cnt_tick cycles are
// queued when the stimulus is driven and matched as the pulses appear.

module tb_stopwatch_ctrl;

   localparam int DEB  = 4;
   localparam int TDIV = 5;

   logic       clk = 1'b0;
   logic       rst;
   logic       start_btn;
   logic       stop_btn;
   logic       cnt_clr;
   logic       cnt_tick;
   logic       running;
   logic [1:0] state;

   int cyc      = 0;
   int checks   = 0;
   int failures = 0;
   int clr_q[$];
   int tick_q[$];
   int mon_exp;
   int e, s, e2, e3, e4, e5, g, p, b, f;

   stopwatch_ctrl #(
      .DEB_CYCLES (DEB),
      .TICK_DIV   (TDIV)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .start_btn (start_btn),
      .stop_btn  (stop_btn),
      .cnt_clr   (cnt_clr),
      .cnt_tick  (cnt_tick),
      .running   (running),
      .state     (state)
   );

   always #5 clk = ~clk;

   // Count rising edges: after edge k, cyc == k.
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   task automatic wait_until(input int c);
      @(negedge clk);
      while (cyc < c) @(negedge clk);
   endtask

   // Scoreboard: match each pulse against the queued expected cycle, and
   // flag expected pulses whose cycle has passed unseen.
   always @(negedge clk) begin
      while (clr_q.size() > 0 && clr_q[0] < cyc) begin
         mon_exp = clr_q.pop_front();
         chk("clr_missing", cyc, mon_exp);
      end
      while (tick_q.size() > 0 && tick_q[0] < cyc) begin
         mon_exp = tick_q.pop_front();
         chk("tick_missing", cyc, mon_exp);
      end
      if (cnt_clr === 1'b1) begin
         if (clr_q.size() > 0) mon_exp = clr_q.pop_front();
         else mon_exp = -1;
         chk("clr_cycle", cyc, mon_exp);
      end
      if (cnt_tick === 1'b1) begin
         if (tick_q.size() > 0) mon_exp = tick_q.pop_front();
         else mon_exp = -1;
         chk("tick_cycle", cyc, mon_exp);
      end
      if (rst === 1'b1) chk("running_vs_state", running, (state == 2'd2));
   end

   initial begin
      #50000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b0;
      start_btn = 1'b1;
      stop_btn = 1'b1;
      wait_until(3);
      chk("rst_state", state, 0);
      chk("rst_clr", cnt_clr, 0);
      chk("rst_tick", cnt_tick, 0);
      chk("rst_running", running, 0);
      wait_until(4);
      rst = 1'b1;

      // Clean start press held 20 cycles: clear at E+7, ticks every 5.
      e = 20;
      wait_until(e - 1);
      start_btn = 1'b0;
      clr_q.push_back(e + 7);
      for (int k = 1; k <= 7; k++) tick_q.push_back(e + 7 + TDIV * k);
      wait_until(e + 6);
      chk("pre_clr_state", state, 0);
      wait_until(e + 7);
      chk("clr_state", state, 1);
      wait_until(e + 8);
      chk("run_state", state, 2);
      chk("run_running", running, 1);
      wait_until(e + 19);
      start_btn = 1'b1;

      // Stop press: HOLD exactly when the next tick would have fallen due.
      s = e + 40;
      wait_until(s - 1);
      stop_btn = 1'b0;
      wait_until(s + 6);
      chk("stop_pre_state", state, 2);
      wait_until(s + 7);
      chk("hold_state", state, 3);
      chk("hold_running", running, 0);
      wait_until(s + 19);
      stop_btn = 1'b1;
      wait_until(s + 220);
      chk("hold_200_state", state, 3);

      // Start from HOLD, then start again while running.
      e2 = s + 230;
      wait_until(e2 - 1);
      start_btn = 1'b0;
      clr_q.push_back(e2 + 7);
      for (int k = 1; k <= 5; k++) tick_q.push_back(e2 + 7 + TDIV * k);
      wait_until(e2 + 7);
      chk("hold_start_clr_state", state, 1);
      wait_until(e2 + 8);
      chk("hold_start_run_state", state, 2);
      wait_until(e2 + 9);
      start_btn = 1'b1;
      e3 = e2 + 30;
      wait_until(e3 - 1);
      start_btn = 1'b0;
      clr_q.push_back(e3 + 7);
      for (int k = 1; k <= 5; k++) tick_q.push_back(e3 + 7 + TDIV * k);
      wait_until(e3 + 7);
      chk("restart_clr_state", state, 1);
      wait_until(e3 + 9);
      start_btn = 1'b1;

      // Simultaneous start+stop from RUN: stop wins, no clear.
      e4 = e3 + 30;
      wait_until(e4 - 1);
      start_btn = 1'b0;
      stop_btn = 1'b0;
      wait_until(e4 + 6);
      chk("both_run_pre_state", state, 2);
      wait_until(e4 + 7);
      chk("both_run_state", state, 3);
      wait_until(e4 + 9);
      start_btn = 1'b1;
      stop_btn = 1'b1;

      // Reset mid-RUN with start held; held button must not restart.
      e5 = e4 + 30;
      wait_until(e5 - 1);
      start_btn = 1'b0;
      clr_q.push_back(e5 + 7);
      tick_q.push_back(e5 + 7 + TDIV);
      wait_until(e5 + 15);
      chk("pre_rst_state", state, 2);
      rst = 1'b0;
      #1;
      chk("async_rst_state", state, 0);
      chk("async_rst_running", running, 0);
      chk("async_rst_clr", cnt_clr, 0);
      chk("async_rst_tick", cnt_tick, 0);
      wait_until(e5 + 18);
      rst = 1'b1;
      wait_until(e5 + 50);
      chk("held_after_rst_state", state, 0);
      start_btn = 1'b1;

      // Three-cycle glitch on start: shorter than the debounce window.
      g = e5 + 70;
      wait_until(g - 1);
      start_btn = 1'b0;
      wait_until(g + 2);
      start_btn = 1'b1;
      wait_until(g + 25);
      chk("glitch_state", state, 0);

      // Stop alone in IDLE stays IDLE.
      p = g + 40;
      wait_until(p - 1);
      stop_btn = 1'b0;
      wait_until(p + 9);
      stop_btn = 1'b1;
      wait_until(p + 20);
      chk("idle_stop_state", state, 0);

      // Simultaneous start+stop in IDLE stays IDLE.
      b = p + 40;
      wait_until(b - 1);
      start_btn = 1'b0;
      stop_btn = 1'b0;
      wait_until(b + 9);
      start_btn = 1'b1;
      stop_btn = 1'b1;
      wait_until(b + 20);
      chk("idle_both_state", state, 0);

      // A fresh press after reset starts normally, then stop.
      f = b + 40;
      wait_until(f - 1);
      start_btn = 1'b0;
      clr_q.push_back(f + 7);
      for (int k = 1; k <= 3; k++) tick_q.push_back(f + 7 + TDIV * k);
      wait_until(f + 8);
      chk("fresh_run_state", state, 2);
      wait_until(f + 9);
      start_btn = 1'b1;
      wait_until(f + 19);
      stop_btn = 1'b0;
      wait_until(f + 27);
      chk("fresh_hold_state", state, 3);
      wait_until(f + 29);
      stop_btn = 1'b1;

      wait_until(f + 60);
      chk("clr_q_empty", clr_q.size(), 0);
      chk("tick_q_empty", tick_q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
